axis_seq_checker: RTL and testbench

AXIS_SEQ_CHECKER -- requirements
Module: axis_seq_checker

---
 rtl/axis_seq_checker.sv | 193 +++++++++++++++++++
 tb/tb_axis_seq_checker.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_seq_checker.sv
// AXI-Stream pass-through with a 2-entry skid FIFO and a per-beat sequence/length checker.
// The checker only observes accepted input beats; the datapath forwards every beat untouched.
module axis_seq_checker #(
  parameter int DATA_W    = 64,
  parameter int PKT_BEATS = 8,
  parameter int SEQ_BYTE  = 7
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  input  logic              clear_stats,
  output logic              pkt_done,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       err_cnt,
  output logic              err_seq,
  output logic              err_len
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BODY   = 2'd1,
    ST_RESYNC = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(PKT_BEATS - 1);

  // ---------------------------------------------------------------- skid FIFO
  logic [DATA_W-1:0] data_q [2];
  logic [1:0]        last_q;
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic [1:0]        count_d;
  logic              tready_q;
  logic              push;
  logic              pop;

  assign push = s_axis_tvalid & tready_q;
  assign pop  = (count_q != 2'd0) & m_axis_tready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
      end
      last_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      tready_q <= 1'b0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= s_axis_tdata;
        last_q[wr_ptr_q] <= s_axis_tlast;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q  <= count_d;
      // Ready comes from next occupancy so it never looks at m_axis_tready combinationally.
      tready_q <= (count_d != 2'd2);
    end
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = (count_q != 2'd0);
  assign m_axis_tdata  = data_q[rd_ptr_q];
  assign m_axis_tlast  = last_q[rd_ptr_q];

  // ------------------------------------------------------------ checker FSM
  state_t     state_q;
  logic [7:0] idx_q;
  logic [7:0] seq_byte;
  logic       seq_err;
  logic       len_err;
  logic       beat_err;
  logic       pkt_evt;

  assign seq_byte = s_axis_tdata[SEQ_BYTE*8 +: 8];
  assign pkt_evt  = push & s_axis_tlast;

  always_comb begin
    seq_err = 1'b0;
    len_err = 1'b0;
    if (push && (state_q != ST_RESYNC)) begin
      seq_err = (seq_byte != idx_q);
      if (s_axis_tlast) begin
        len_err = (idx_q < LAST_IDX);
      end else begin
        len_err = (idx_q == LAST_IDX);
      end
    end
  end

  assign beat_err = seq_err | len_err;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
      idx_q   <= 8'd0;
    end else if (push) begin
      case (state_q)
        ST_IDLE, ST_BODY: begin
          if (s_axis_tlast) begin
            state_q <= ST_IDLE;
            idx_q   <= 8'd0;
          end else if (idx_q == LAST_IDX) begin
            state_q <= ST_RESYNC;
            idx_q   <= 8'd0;
          end else begin
            state_q <= ST_BODY;
            idx_q   <= idx_q + 8'd1;
          end
        end
        ST_RESYNC: begin
          if (s_axis_tlast) begin
            state_q <= ST_IDLE;
          end
          idx_q <= 8'd0;
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= 8'd0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------- statistics
  logic        pkt_done_q;
  logic [15:0] pkt_cnt_q;
  logic [15:0] pkt_cnt_d;
  logic [15:0] err_cnt_q;
  logic [15:0] err_cnt_d;
  logic        err_seq_q;
  logic        err_seq_d;
  logic        err_len_q;
  logic        err_len_d;

  // A clear in the same cycle as an event wipes the old value first, then counts the event.
  always_comb begin
    pkt_cnt_d = clear_stats ? 16'd0 : pkt_cnt_q;
    err_cnt_d = clear_stats ? 16'd0 : err_cnt_q;
    err_seq_d = clear_stats ? 1'b0  : err_seq_q;
    err_len_d = clear_stats ? 1'b0  : err_len_q;
    pkt_cnt_d = pkt_cnt_d + {15'd0, pkt_evt};
    if (beat_err && (err_cnt_d != 16'hFFFF)) begin
      err_cnt_d = err_cnt_d + 16'd1;
    end
    err_seq_d = err_seq_d | seq_err;
    err_len_d = err_len_d | len_err;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      pkt_done_q <= 1'b0;
      pkt_cnt_q  <= 16'd0;
      err_cnt_q  <= 16'd0;
      err_seq_q  <= 1'b0;
      err_len_q  <= 1'b0;
    end else begin
      pkt_done_q <= pkt_evt;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_seq_q  <= err_seq_d;
      err_len_q  <= err_len_d;
    end
  end

  assign pkt_done = pkt_done_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign err_seq  = err_seq_q;
  assign err_len  = err_len_q;

endmodule

// File: tb/tb_axis_seq_checker.sv
// Randomised scoreboard bench for axis_seq_checker: a driver issues packets, a negedge
// monitor predicts FIFO contents and packet statistics from a packet-level reference model.
module tb_axis_seq_checker;
  localparam int DATA_W    = 64;
  localparam int PKT_BEATS = 8;
  localparam int SEQ_BYTE  = 7;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic              s_axis_tlast = 1'b0;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tlast;
  logic              clear_stats = 1'b0;
  logic              pkt_done;
  logic [15:0]       pkt_cnt;
  logic [15:0]       err_cnt;
  logic              err_seq;
  logic              err_len;

  axis_seq_checker #(.DATA_W(DATA_W), .PKT_BEATS(PKT_BEATS), .SEQ_BYTE(SEQ_BYTE)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .clear_stats(clear_stats), .pkt_done(pkt_done),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .err_seq(err_seq), .err_len(err_len)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  beat_t exp_q[$];
  bit    mon_en = 1'b0;
  bit    exp_done = 1'b0;
  int    ready_mode = 0;
  int    cyc = 0;

  // Reference model: position within the current packet and whether we are discarding.
  int m_pos = 0;
  bit m_discard = 1'b0;
  int m_pkt = 0;
  int m_err = 0;
  bit m_seq = 1'b0;
  bit m_len = 1'b0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void model_clear();
    m_pkt = 0;
    m_err = 0;
    m_seq = 1'b0;
    m_len = 1'b0;
  endfunction

  function automatic void model_beat(input logic [7:0] seq, input logic last);
    bit e_seq;
    bit e_len;
    e_seq = 1'b0;
    e_len = 1'b0;
    if (m_discard) begin
      if (last) m_discard = 1'b0;
      m_pos = 0;
    end else begin
      e_seq = (int'(seq) != m_pos);
      e_len = last ? (m_pos < PKT_BEATS - 1) : (m_pos == PKT_BEATS - 1);
      if (last) m_pos = 0;
      else if (e_len) begin m_discard = 1'b1; m_pos = 0; end
      else m_pos++;
    end
    if (e_seq || e_len) m_err = (m_err < 65535) ? m_err + 1 : m_err;
    m_seq = m_seq | e_seq;
    m_len = m_len | e_len;
    if (last) m_pkt = (m_pkt + 1) % 65536;
  endfunction

  // Monitor: all scoreboard bookkeeping happens here, on the falling edge.
  always @(negedge aclk) begin
    beat_t b;
    if (mon_en) begin
      check("s_tready_vs_occupancy", s_axis_tready, exp_q.size() < 2);
      check("m_tvalid_vs_occupancy", m_axis_tvalid, exp_q.size() > 0);
      check("pkt_done_pulse", pkt_done, exp_done);
      if (m_axis_tvalid && m_axis_tready && exp_q.size() > 0) begin
        b = exp_q.pop_front();
        $display("beat out: data=0x%016h last=%0b", m_axis_tdata, m_axis_tlast);
        check("m_tdata", m_axis_tdata, b.data);
        check("m_tlast", m_axis_tlast, b.last);
      end
      if (clear_stats) model_clear();
      exp_done = 1'b0;
      if (s_axis_tvalid && s_axis_tready) begin
        exp_q.push_back({s_axis_tlast, s_axis_tdata});
        model_beat(s_axis_tdata[SEQ_BYTE*8 +: 8], s_axis_tlast);
        exp_done = s_axis_tlast;
      end
    end
  end

  // Downstream ready pattern, updated shortly after each rising edge.
  always begin
    @(posedge aclk);
    #2;
    cyc++;
    case (ready_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = (cyc % 8) >= 2;
      2:       m_axis_tready = ($urandom_range(0, 3) != 0);
      default: m_axis_tready = 1'b0;
    endcase
  end

  task automatic send_beat(input logic [7:0] seq, input logic last, input bit clr);
    logic [DATA_W-1:0] d;
    d = {$urandom, $urandom};
    d[SEQ_BYTE*8 +: 8] = seq;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    clear_stats   = clr;
    for (int t = 0; ; t++) begin
      @(negedge aclk);
      if (s_axis_tready) break;
      if (t >= 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: got no s_axis_tready, required acceptance within 200 cycles");
        break;
      end
    end
    @(posedge aclk);
    #1;
    clear_stats = 1'b0;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic send_pkt(input int n, input int bad_idx, input logic [7:0] bad_val, input int max_gap);
    logic [7:0] seq;
    for (int i = 0; i < n; i++) begin
      seq = (i == bad_idx) ? bad_val : 8'(i);
      send_beat(seq, i == n - 1, 1'b0);
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
    idle(1);
  endtask

  task automatic pulse_clear();
    clear_stats = 1'b1;
    @(posedge aclk); #1;
    clear_stats = 1'b0;
  endtask

  task automatic drain_and_check(input string name);
    ready_mode = 0;
    for (int t = 0; exp_q.size() != 0; t++) begin
      if (t >= 500) begin
        n_cmp++;
        n_bad++;
        $display("FAIL drain_timeout_%s: got %0d beats left, required 0", name, exp_q.size());
        break;
      end
      @(posedge aclk);
    end
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check({name, "_pkt_cnt"}, pkt_cnt, m_pkt);
    check({name, "_err_cnt"}, err_cnt, m_err);
    check({name, "_err_seq"}, err_seq, m_seq);
    check({name, "_err_len"}, err_len, m_len);
    $display("%s: pkt_cnt=%0d err_cnt=%0d err_seq=%0b err_len=%0b", name, pkt_cnt, err_cnt, err_seq, err_len);
    @(posedge aclk); #1;
  endtask

  task automatic do_reset(input string name);
    mon_en = 1'b0;
    areset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    clear_stats   = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check({name, "_tready_in_reset"}, s_axis_tready, 0);
    check({name, "_m_tvalid_rst"}, m_axis_tvalid, 0);
    check({name, "_m_tdata_rst"}, m_axis_tdata, 0);
    check({name, "_m_tlast_rst"}, m_axis_tlast, 0);
    check({name, "_stats_rst"}, {pkt_done, pkt_cnt, err_cnt, err_seq, err_len}, 0);
    exp_q.delete();
    model_clear();
    m_pos = 0;
    m_discard = 1'b0;
    exp_done = 1'b0;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check({name, "_tready_after_rst"}, s_axis_tready, 1);
    mon_en = 1'b1;
    @(posedge aclk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no $finish, required end of test before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len;
    int bad;
    do_reset("reset0");

    ready_mode = 0;
    send_pkt(8, -1, 8'h00, 0);
    drain_and_check("clean");

    pulse_clear();
    ready_mode = 1;
    send_pkt(8, -1, 8'h00, 0);
    drain_and_check("backpressure");

    pulse_clear();
    send_pkt(8, 3, 8'h05, 0);
    drain_and_check("seq_err");

    pulse_clear();
    send_pkt(5, -1, 8'h00, 0);
    send_pkt(8, -1, 8'h00, 0);
    drain_and_check("early_tlast");

    pulse_clear();
    send_pkt(10, -1, 8'h00, 0);
    drain_and_check("missing_tlast");
    send_pkt(8, -1, 8'h00, 0);
    drain_and_check("after_resync");

    send_beat(8'h03, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) send_beat(8'(i), i == 7, 1'b0);
    idle(1);
    drain_and_check("clear_with_event");

    ready_mode = 0;
    send_beat(8'h00, 1'b0, 1'b0);
    send_beat(8'h01, 1'b0, 1'b0);
    send_beat(8'h02, 1'b0, 1'b0);
    ready_mode = 3;
    idle(1);
    do_reset("reset_mid");
    ready_mode = 0;
    send_pkt(8, -1, 8'h00, 0);
    drain_and_check("post_reset");

    ready_mode = 2;
    for (int p = 0; p < 25; p++) begin
      case ($urandom_range(0, 9))
        6:       len = $urandom_range(2, PKT_BEATS - 1);
        7:       len = $urandom_range(PKT_BEATS + 1, PKT_BEATS + 3);
        default: len = PKT_BEATS;
      endcase
      bad = ($urandom_range(0, 9) < 3) ? $urandom_range(0, len - 1) : -1;
      send_pkt(len, bad, 8'($urandom_range(0, 255)), $urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) pulse_clear();
      ready_mode = 2;
    end
    drain_and_check("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
